line_buffer_frame_scheduler: RTL and testbench

//  Sequences one conv layer through the stride/padding line-buffer control path, channel by channel.
//  Per channel: pulses lb_sof, reads IMG_W*IMG_W pixels from feature-map memory and streams them as
//  lb_input_valid/lb_data, then counts lb_output_valid windows until the expected count is reached.

---
 rtl/line_buffer_frame_scheduler_if.sv | 24 ++
 rtl/line_buffer_frame_scheduler.sv | 139 +++++++++++++
 tb/tb_line_buffer_frame_scheduler.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_buffer_frame_scheduler_if.sv
// Memory read port and line-buffer stream port of the frame scheduler.
// The scheduler is the master. Memory and line-buffer control sit on the slave side.
interface line_buffer_frame_scheduler_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              lb_sof;
  logic              lb_input_valid;
  logic [DATA_W-1:0] lb_data;
  logic              lb_output_valid;

  modport master (
    output mem_rd_en, mem_addr, lb_sof, lb_input_valid, lb_data,
    input  mem_rd_data, lb_output_valid
  );

  modport slave (
    input  mem_rd_en, mem_addr, lb_sof, lb_input_valid, lb_data,
    output mem_rd_data, lb_output_valid
  );
endinterface

// File: rtl/line_buffer_frame_scheduler.sv
// Runs one conv layer channel by channel. For each channel it pulses lb_sof, streams
// IMG_W*IMG_W pixels from memory into the line buffer, then waits for the expected window count.
module line_buffer_frame_scheduler #(
  parameter int IMG_W         = 64,
  parameter int STRIDE        = 2,
  parameter int NUM_CH        = 4,
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 16,
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic [ADDR_W-1:0]             i_cfg_base_addr,
  input  logic                          i_stall,
  line_buffer_frame_scheduler_if.master bus,
  output logic [7:0]                    o_ch_idx,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err
);

  localparam int PIX    = IMG_W * IMG_W;
  localparam int PIX_CW = $clog2(PIX + 1);
  localparam int OUT_W  = (IMG_W - 3) / STRIDE + 1;
  localparam int DR_W   = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [PIX_CW-1:0] PIX_END   = PIX_CW'(PIX);
  localparam logic [PIX_CW-1:0] PIX_LAST  = PIX_CW'(PIX - 1);
  localparam logic [15:0]       EXP_WIN   = 16'(OUT_W * OUT_W);
  localparam logic [15:0]       WIN_MAX   = 16'hFFFF;
  localparam logic [DR_W-1:0]   DRAIN_LIM = DR_W'(DRAIN_TIMEOUT);
  localparam logic [7:0]        LAST_CH   = 8'(NUM_CH - 1);
  localparam logic [ADDR_W-1:0] CH_STEP   = ADDR_W'(PIX);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SOF     = 3'd1;
  localparam logic [2:0] S_STREAM  = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_NEXT_CH = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_ch_base;
  logic [7:0]        r_ch_idx;
  logic [PIX_CW-1:0] r_pix_cnt;
  logic [15:0]       r_win_cnt;
  logic [DR_W-1:0]   r_drain_cnt;
  logic              r_rd_en_d;
  logic              r_err;

  logic              w_rd_en;
  logic              w_win_state;
  logic              w_over;
  logic              w_win_inc;
  logic [DATA_W-1:0] w_pix;

  assign w_rd_en     = (r_state == S_STREAM) && !i_stall && (r_pix_cnt != PIX_END);
  assign w_win_state = (r_state == S_STREAM) || (r_state == S_DRAIN) || (r_state == S_NEXT_CH);
  assign w_over      = bus.lb_output_valid && w_win_state && (r_win_cnt == EXP_WIN);
  // Counting stops at EXP_WIN, so an extra window only raises err and DRAIN still sees the exact count.
  assign w_win_inc   = bus.lb_output_valid && ((r_state == S_STREAM) || (r_state == S_DRAIN)) &&
                       (r_win_cnt != EXP_WIN) && (r_win_cnt != WIN_MAX);
  assign w_pix       = bus.mem_rd_data;

  // r_ch_base already includes the channel offset, so there is no multiply on the address path.
  assign bus.mem_rd_en      = w_rd_en;
  assign bus.mem_addr       = r_ch_base + ADDR_W'(r_pix_cnt);
  assign bus.lb_sof         = (r_state == S_SOF);
  assign bus.lb_input_valid = r_rd_en_d;
  assign bus.lb_data        = w_pix;

  assign o_ch_idx = r_ch_idx;
  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = (r_state == S_DONE);
  assign o_err    = r_err;

  // NOTE: all state updates use non-blocking assignments so every register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ch_base   <= '0;
      r_ch_idx    <= '0;
      r_pix_cnt   <= '0;
      r_win_cnt   <= '0;
      r_drain_cnt <= '0;
      r_rd_en_d   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rd_en_d <= w_rd_en;
      if (w_rd_en)   r_pix_cnt <= r_pix_cnt + 1'b1;
      if (w_win_inc) r_win_cnt <= r_win_cnt + 16'd1;
      if (w_over)    r_err     <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_ch_base <= i_cfg_base_addr;
            r_ch_idx  <= '0;
            r_err     <= 1'b0;
            r_state   <= S_SOF;
          end
        end
        S_SOF: begin
          r_pix_cnt   <= '0;
          r_win_cnt   <= '0;
          r_drain_cnt <= '0;
          r_state     <= S_STREAM;
        end
        S_STREAM: begin
          // The last pixel comes back from memory in the first DRAIN cycle.
          if (w_rd_en && (r_pix_cnt == PIX_LAST)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_win_cnt == EXP_WIN) begin
            r_state <= S_NEXT_CH;
          end else if (r_drain_cnt == DRAIN_LIM) begin
            r_err   <= 1'b1;
            r_state <= S_NEXT_CH;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        S_NEXT_CH: begin
          if (r_ch_idx == LAST_CH) begin
            r_state <= S_DONE;
          end else begin
            r_ch_idx  <= r_ch_idx + 8'd1;
            r_ch_base <= r_ch_base + CH_STEP;
            r_state   <= S_SOF;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_buffer_frame_scheduler.sv
// Directed bench for line_buffer_frame_scheduler with an 8x8, stride-2, 2-channel layer.
// It models the memory (data = addr ^ 0x5A5A, 1-cycle latency) and line-buffer control (9 windows per channel).
module tb_line_buffer_frame_scheduler;
  localparam int IMG_W = 8, STRIDE = 2, NUM_CH = 2, DATA_W = 16, ADDR_W = 16, DRAIN_TIMEOUT = 255;
  localparam int PIX = IMG_W * IMG_W;
  localparam int LAYER_CYC = 135;   // start cycle to done cycle: 2 x (SOF + 64 STREAM + DRAIN + NEXT_CH) + 1
  localparam logic [15:0] DKEY = 16'h5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [15:0] i_base;
  logic        i_stall;
  logic [7:0]  o_ch_idx;
  logic        o_busy, o_done, o_err;

  line_buffer_frame_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  line_buffer_frame_scheduler #(
    .IMG_W(IMG_W), .STRIDE(STRIDE), .NUM_CH(NUM_CH),
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_cfg_base_addr(i_base), .i_stall(i_stall),
    .bus(bus), .o_ch_idx(o_ch_idx), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Memory and line-buffer-control model: inputs are driven 1 ns after the edge.
  logic        m_en = 1'b0;
  logic [15:0] m_addr = '0;
  int plan[2];
  int model_ch = -1, model_pix = 0, model_win = 0, tenth_cyc = -1;

  function automatic bit is_win(int p);
    int r = p / IMG_W;
    int c = p % IMG_W;
    return (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
  endfunction

  always @(posedge clk) begin
    #1;
    bus.mem_rd_data     = m_en ? (m_addr ^ DKEY) : 16'h0;
    bus.lb_output_valid = 1'b0;
    if (bus.lb_sof) begin
      model_ch++;
      model_pix = 0;
      model_win = 0;
    end
    if (bus.lb_input_valid && model_ch >= 0 && model_ch < 2) begin
      if ((is_win(model_pix) && model_win < plan[model_ch]) ||
          (plan[model_ch] == 10 && model_pix == PIX - 1)) begin
        bus.lb_output_valid = 1'b1;
        model_win++;
        if (model_win == 10) tenth_cyc = cyc;
      end
      model_pix++;
    end
  end

  // Monitor, sampling at the falling edge.
  logic [15:0] q_addr[$];
  logic [15:0] q_data[$];
  int sof_cnt, done_cnt, rd_in_stall, sof_clash, err_rise_cyc, err_gap, last_valid_cyc;
  bit err_prev = 1'b0;

  always @(negedge clk) begin
    m_en   = bus.mem_rd_en;
    m_addr = bus.mem_addr;
    if (bus.mem_rd_en) q_addr.push_back(bus.mem_addr);
    if (bus.mem_rd_en && i_stall) rd_in_stall++;
    if (bus.lb_input_valid) q_data.push_back(bus.lb_data);
    if (bus.lb_sof) sof_cnt++;
    if (bus.lb_sof && bus.lb_input_valid) sof_clash++;
    if (o_done) done_cnt++;
    if (o_err && !err_prev) begin
      err_rise_cyc = cyc;
      err_gap      = cyc - last_valid_cyc;
    end
    err_prev = o_err;
    if (bus.lb_input_valid) last_valid_cyc = cyc;
  end

  int start_cyc, done_at;

  task automatic clear_mon();
    q_addr.delete();
    q_data.delete();
    sof_cnt = 0; done_cnt = 0; rd_in_stall = 0; sof_clash = 0;
    err_rise_cyc = -1; err_gap = -1; last_valid_cyc = 0;
    model_ch = -1; tenth_cyc = -1;
  endtask

  task automatic pulse_start(input logic [15:0] b);
    @(posedge clk); #1;
    i_start = 1'b1; i_base = b; start_cyc = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_done) begin
        to = 1'b0;
        done_at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_base = '0; i_stall = 1'b0;
    bus.mem_rd_data = '0; bus.lb_output_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (o_busy !== 1'b0)            begin n_bad++; $display("FAIL reset_busy got %0b want 0", o_busy); end
    n_cmp++; if (o_done !== 1'b0)            begin n_bad++; $display("FAIL reset_done got %0b want 0", o_done); end
    n_cmp++; if (o_err !== 1'b0)             begin n_bad++; $display("FAIL reset_err got %0b want 0", o_err); end
    n_cmp++; if (o_ch_idx !== 8'd0)          begin n_bad++; $display("FAIL reset_ch_idx got %0d want 0", o_ch_idx); end
    n_cmp++; if (bus.mem_rd_en !== 1'b0)     begin n_bad++; $display("FAIL reset_rd_en got %0b want 0", bus.mem_rd_en); end
    n_cmp++; if (bus.mem_addr !== 16'h0)     begin n_bad++; $display("FAIL reset_addr got %h want 0", bus.mem_addr); end
    n_cmp++; if (bus.lb_sof !== 1'b0)        begin n_bad++; $display("FAIL reset_sof got %0b want 0", bus.lb_sof); end
    n_cmp++; if (bus.lb_input_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", bus.lb_input_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit to;
    logic [15:0] exp_a;
    clear_mon(); plan[0] = 9; plan[1] = 9;
    pulse_start(16'h0100);
    wait_done(400, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL basic_done_timeout got timeout want done"); end
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_in_done got %0b want 1", o_busy); end
    n_cmp++; if (done_at - start_cyc !== LAYER_CYC) begin n_bad++; $display("FAIL basic_duration got %0d want %0d", done_at - start_cyc, LAYER_CYC); end
    @(negedge clk);
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after got %0b want 0", o_busy); end
    n_cmp++; if (o_ch_idx !== 8'd1) begin n_bad++; $display("FAIL basic_ch_idx_hold got %0d want 1", o_ch_idx); end
    n_cmp++; if (q_addr.size() !== 128) begin n_bad++; $display("FAIL basic_rd_count got %0d want 128", q_addr.size()); end
    n_cmp++; if (q_data.size() !== 128) begin n_bad++; $display("FAIL basic_valid_count got %0d want 128", q_data.size()); end
    for (int i = 0; i < 128 && i < q_addr.size() && i < q_data.size(); i++) begin
      exp_a = 16'h0100 + 16'(i);
      n_cmp++; if (q_addr[i] !== exp_a) begin n_bad++; $display("FAIL basic_addr[%0d] got %h want %h", i, q_addr[i], exp_a); end
      n_cmp++; if (q_data[i] !== (exp_a ^ DKEY)) begin n_bad++; $display("FAIL basic_data[%0d] got %h want %h", i, q_data[i], exp_a ^ DKEY); end
    end
    n_cmp++; if (sof_cnt !== 2) begin n_bad++; $display("FAIL basic_sof_count got %0d want 2", sof_cnt); end
    n_cmp++; if (sof_clash !== 0) begin n_bad++; $display("FAIL basic_sof_with_valid got %0d want 0", sof_clash); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL basic_done_width got %0d want 1", done_cnt); end
    n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL basic_err got %0b want 0", o_err); end
  endtask

  task automatic test_stall();
    bit to;
    logic [15:0] exp_a;
    clear_mon(); plan[0] = 9; plan[1] = 9;
    pulse_start(16'h0100);
    for (int i = 0; i < 100 && q_addr.size() < 20; i++) @(negedge clk);
    @(posedge clk); #1; i_stall = 1'b1;
    repeat (3) @(posedge clk);
    #1; i_stall = 1'b0;
    wait_done(400, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL stall_done_timeout got timeout want done"); end
    n_cmp++; if (done_at - start_cyc !== LAYER_CYC + 3) begin n_bad++; $display("FAIL stall_duration got %0d want %0d", done_at - start_cyc, LAYER_CYC + 3); end
    @(negedge clk);
    n_cmp++; if (rd_in_stall !== 0) begin n_bad++; $display("FAIL stall_rd_during_stall got %0d want 0", rd_in_stall); end
    n_cmp++; if (q_data.size() !== 128) begin n_bad++; $display("FAIL stall_valid_count got %0d want 128", q_data.size()); end
    for (int i = 0; i < 128 && i < q_addr.size() && i < q_data.size(); i++) begin
      exp_a = 16'h0100 + 16'(i);
      n_cmp++; if (q_addr[i] !== exp_a) begin n_bad++; $display("FAIL stall_addr[%0d] got %h want %h", i, q_addr[i], exp_a); end
      n_cmp++; if (q_data[i] !== (exp_a ^ DKEY)) begin n_bad++; $display("FAIL stall_data[%0d] got %h want %h", i, q_data[i], exp_a ^ DKEY); end
    end
    n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL stall_err got %0b want 0", o_err); end
  endtask

  task automatic test_drain_timeout();
    bit to;
    clear_mon(); plan[0] = 8; plan[1] = 9;
    pulse_start(16'h0100);
    wait_done(800, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL timeout_done_timeout got timeout want done"); end
    @(negedge clk);
    n_cmp++; if (err_gap < DRAIN_TIMEOUT || err_gap > DRAIN_TIMEOUT + 2)
      begin n_bad++; $display("FAIL timeout_err_delay got %0d want %0d..%0d", err_gap, DRAIN_TIMEOUT, DRAIN_TIMEOUT + 2); end
    n_cmp++; if (q_data.size() !== 128) begin n_bad++; $display("FAIL timeout_valid_count got %0d want 128", q_data.size()); end
    n_cmp++; if (sof_cnt !== 2) begin n_bad++; $display("FAIL timeout_sof_count got %0d want 2", sof_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL timeout_done_count got %0d want 1", done_cnt); end
    repeat (2) @(negedge clk);
    n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL timeout_err_sticky got %0b want 1", o_err); end
  endtask

  task automatic test_overcount();
    bit to;
    clear_mon(); plan[0] = 10; plan[1] = 9;
    pulse_start(16'h0100);
    @(negedge clk);
    n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL over_err_cleared_on_start got %0b want 0", o_err); end
    wait_done(400, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL over_done_timeout got timeout want done"); end
    n_cmp++; if (done_at - start_cyc !== LAYER_CYC) begin n_bad++; $display("FAIL over_duration got %0d want %0d", done_at - start_cyc, LAYER_CYC); end
    @(negedge clk);
    n_cmp++; if (err_rise_cyc !== tenth_cyc + 1) begin n_bad++; $display("FAIL over_err_cycle got %0d want %0d", err_rise_cyc, tenth_cyc + 1); end
    n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL over_err got %0b want 1", o_err); end
    n_cmp++; if (q_addr.size() !== 128) begin n_bad++; $display("FAIL over_rd_count got %0d want 128", q_addr.size()); end
    n_cmp++; if (sof_cnt !== 2) begin n_bad++; $display("FAIL over_sof_count got %0d want 2", sof_cnt); end
  endtask

  task automatic test_start_while_busy();
    bit to;
    logic [15:0] exp_a;
    clear_mon(); plan[0] = 9; plan[1] = 9;
    pulse_start(16'h0100);
    for (int i = 0; i < 100 && q_addr.size() < 30; i++) @(negedge clk);
    @(posedge clk); #1; i_start = 1'b1; i_base = 16'h0200;
    @(posedge clk); #1; i_start = 1'b0; i_base = 16'h0100;
    wait_done(400, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL busy_done_timeout got timeout want done"); end
    n_cmp++; if (done_at - start_cyc !== LAYER_CYC) begin n_bad++; $display("FAIL busy_duration got %0d want %0d", done_at - start_cyc, LAYER_CYC); end
    @(negedge clk);
    n_cmp++; if (q_addr.size() !== 128) begin n_bad++; $display("FAIL busy_rd_count got %0d want 128", q_addr.size()); end
    for (int i = 0; i < 128 && i < q_addr.size(); i++) begin
      exp_a = 16'h0100 + 16'(i);
      n_cmp++; if (q_addr[i] !== exp_a) begin n_bad++; $display("FAIL busy_addr[%0d] got %h want %h", i, q_addr[i], exp_a); end
    end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL busy_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_layer();
    bit to;
    clear_mon(); plan[0] = 9; plan[1] = 9;
    pulse_start(16'h0100);
    for (int i = 0; i < 300 && q_addr.size() < PIX + 10; i++) @(negedge clk);
    n_cmp++; if (o_ch_idx !== 8'd1) begin n_bad++; $display("FAIL rstmid_in_ch1 got %0d want 1", o_ch_idx); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %0b want 0", o_busy); end
    n_cmp++; if (bus.mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_rd_en got %0b want 0", bus.mem_rd_en); end
    n_cmp++; if (bus.lb_input_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %0b want 0", bus.lb_input_valid); end
    n_cmp++; if (o_ch_idx !== 8'd0) begin n_bad++; $display("FAIL rstmid_ch_idx got %0d want 0", o_ch_idx); end
    repeat (20) @(negedge clk);
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL rstmid_no_done got %0d want 0", done_cnt); end
    clear_mon();
    pulse_start(16'h0100);
    wait_done(400, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rstmid_restart_timeout got timeout want done"); end
    @(negedge clk);
    n_cmp++; if (q_addr.size() !== 128) begin n_bad++; $display("FAIL rstmid_restart_count got %0d want 128", q_addr.size()); end
    if (q_addr.size() > 0) begin
      n_cmp++; if (q_addr[0] !== 16'h0100) begin n_bad++; $display("FAIL rstmid_restart_addr0 got %h want 0100", q_addr[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_drain_timeout();
    test_overcount();
    test_start_while_busy();
    test_reset_mid_layer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
